// File: rtl/rll_key_pkg.sv
// Shared definitions for the RLL16 key loader: FSM state encoding and
// default parameter values.
package rll_key_pkg;

  localparam int KEY_WIDTH_DEF = 16;
  localparam int MAX_FAIL_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOCKED = 2'd2
  } rll_key_state_t;

endpackage

// File: rtl/rll_key_shreg.sv
// Shadow shift register for the serial key, MSB first, with a running
// XOR of every data bit shifted in and a synchronous clear.
module rll_key_shreg
  import rll_key_pkg::*;
#(
  parameter int WIDTH = KEY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] shadow_o,
  output logic             parity_o
);

  logic [WIDTH-1:0] shadow_q;
  logic             parity_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      shadow_q <= '0;
      parity_q <= 1'b0;
    end else if (shift_i) begin
      shadow_q <= {shadow_q[WIDTH-2:0], bit_i};
      parity_q <= parity_q ^ bit_i;
    end
  end

  assign shadow_o = shadow_q;
  assign parity_o = parity_q;

endmodule

// File: rtl/rll_key_loader.sv
// Bit-serial key loader: checks even parity over key plus parity bit,
// commits the key atomically and locks out after repeated failures.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int MAX_FAIL  = MAX_FAIL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_good,
  output logic                 commit,
  output logic                 load_err,
  output logic                 lockout
);

  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  rll_key_state_t state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FW-1:0]        fail_q, fail_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 good_q, good_d;
  logic                 commit_q, commit_d;
  logic                 err_q, err_d;
  logic                 lock_q, lock_d;
  logic                 ready_q, ready_d;

  logic                 clear, shift, accept, parity;
  logic [KEY_WIDTH-1:0] shadow;
  logic [FW-1:0]        fail_inc;

  rll_key_shreg #(.WIDTH(KEY_WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .shift_i  (shift),
    .bit_i    (bit_in),
    .shadow_o (shadow),
    .parity_o (parity)
  );

  // ready_q is high exactly while in SHIFT, so it doubles as the accept gate
  assign accept   = bit_valid & ready_q;
  assign fail_inc = fail_q + FW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    key_d    = key_q;
    good_d   = good_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    lock_d   = lock_q;
    clear    = 1'b0;
    shift    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (load_start) begin
          clear = 1'b1;
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q < CW'(KEY_WIDTH)) begin
            shift = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end else if ((parity ^ bit_in) == 1'b0) begin
            key_d    = shadow;
            good_d   = 1'b1;
            commit_d = 1'b1;
            fail_d   = '0;
            state_d  = IDLE;
          end else begin
            err_d = 1'b1;
            if (fail_q != FW'(MAX_FAIL)) fail_d = fail_inc;
            if (fail_inc == FW'(MAX_FAIL)) begin
              key_d   = '0;
              good_d  = 1'b0;
              lock_d  = 1'b1;
              state_d = LOCKED;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      LOCKED: begin
        key_d  = '0;
        good_d = 1'b0;
        lock_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fail_q   <= '0;
      key_q    <= '0;
      good_q   <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      key_q    <= key_d;
      good_q   <= good_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      lock_q   <= lock_d;
      ready_q  <= ready_d;
    end
  end

  assign bit_ready = ready_q;
  assign key_out   = key_q;
  assign key_good  = good_q;
  assign commit    = commit_q;
  assign load_err  = err_q;
  assign lockout   = lock_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Randomized bench for rll_key_loader: a transaction-level model built from
// a queue of received bits is compared against the DUT every cycle.
module tb_rll_key_loader;

  localparam int KW = 16;
  localparam int MF = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          loadStart = 1'b0;
  logic          bitIn = 1'b0;
  logic          bitValid = 1'b0;
  logic          bitReady;
  logic [KW-1:0] keyOut;
  logic          keyGood, commitPulse, loadErr, lockoutLvl;

  int checks = 0;
  int passes = 0;
  bit checkEn = 1'b0;

  rll_key_loader #(.KEY_WIDTH(KW), .MAX_FAIL(MF)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (loadStart),
    .bit_in     (bitIn),
    .bit_valid  (bitValid),
    .bit_ready  (bitReady),
    .key_out    (keyOut),
    .key_good   (keyGood),
    .commit     (commitPulse),
    .load_err   (loadErr),
    .lockout    (lockoutLvl)
  );

  always #5 clk = ~clk;

  // Model: a load is "in progress" or not; bits collect in a queue and the
  // 17th bit decides the outcome from the count of ones.
  bit            mLoading, mLocked, mGood, mCommit, mErr;
  logic [KW-1:0] mKey;
  int            mFails;
  bit            mBits[$];

  always @(posedge clk) begin
    int ones;
    mCommit = 1'b0;
    mErr    = 1'b0;
    if (rst) begin
      mLoading = 1'b0;
      mLocked  = 1'b0;
      mGood    = 1'b0;
      mKey     = '0;
      mFails   = 0;
      mBits.delete();
    end else if (!mLocked) begin
      if (loadStart) begin
        mLoading = 1'b1;
        mBits.delete();
      end else if (mLoading && bitValid) begin
        if (mBits.size() < KW) begin
          mBits.push_back(bitIn);
        end else begin
          ones = int'(bitIn);
          foreach (mBits[i]) ones += int'(mBits[i]);
          if (ones % 2 == 0) begin
            for (int i = 0; i < KW; i++) mKey[KW-1-i] = mBits[i];
            mGood   = 1'b1;
            mCommit = 1'b1;
            mFails  = 0;
          end else begin
            mErr   = 1'b1;
            mFails = (mFails < MF) ? mFails + 1 : MF;
            if (mFails == MF) begin
              mLocked = 1'b1;
              mKey    = '0;
              mGood   = 1'b0;
            end
          end
          mLoading = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc key_out", 32'(keyOut), 32'(mKey));
      checkOutput("cyc key_good", 32'(keyGood), 32'(mGood));
      checkOutput("cyc commit", 32'(commitPulse), 32'(mCommit));
      checkOutput("cyc load_err", 32'(loadErr), 32'(mErr));
      checkOutput("cyc lockout", 32'(lockoutLvl), 32'(mLocked));
      checkOutput("cyc bit_ready", 32'(bitReady), 32'(mLoading && !mLocked));
    end
  end

  task automatic doReset(input int cycles);
    rst = 1'b1;
    loadStart = 1'b0;
    bitValid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full load: start pulse (with a random discarded bit), then 16 key bits
  // MSB first and the parity bit, each preceded by 0..maxGap idle cycles.
  task automatic applyStimulus(input logic [KW-1:0] key, input logic par, input int maxGap);
    loadStart = 1'b1;
    bitValid = 1'($urandom_range(0, 1));
    bitIn = 1'($urandom);
    @(negedge clk);
    loadStart = 1'b0;
    for (int i = 0; i <= KW; i++) begin
      repeat ($urandom_range(0, maxGap)) begin
        bitValid = 1'b0;
        bitIn = 1'($urandom);
        @(negedge clk);
      end
      bitValid = 1'b1;
      bitIn = (i < KW) ? key[KW-1-i] : par;
      @(negedge clk);
    end
    bitValid = 1'b0;
  endtask

  task automatic applyPartial(input int n);
    loadStart = 1'b1;
    bitValid = 1'b0;
    @(negedge clk);
    loadStart = 1'b0;
    repeat (n) begin
      bitValid = 1'b1;
      bitIn = 1'($urandom);
      @(negedge clk);
    end
    bitValid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [KW-1:0] rk;
    logic          rp;
    @(negedge clk);
    checkEn = 1'b1;
    rst = 1'b0;
    checkOutput("reset key_out", 32'(keyOut), 32'h0);
    checkOutput("reset bit_ready", 32'(bitReady), 32'h0);

    applyStimulus(16'hA5C3, 1'b0, 0);
    checkOutput("A5C3 commit", 32'(commitPulse), 32'h1);
    checkOutput("A5C3 key", 32'(keyOut), 32'hA5C3);
    checkOutput("A5C3 model key", 32'(mKey), 32'hA5C3);

    applyStimulus(16'h1234, 1'b1, 0);
    checkOutput("1234 key", 32'(keyOut), 32'h1234);
    applyStimulus(16'hA5C3, 1'b1, 0);
    checkOutput("bad load_err", 32'(loadErr), 32'h1);
    checkOutput("bad key kept", 32'(keyOut), 32'h1234);
    checkOutput("bad key_good", 32'(keyGood), 32'h1);
    checkOutput("model failCount", 32'(mFails), 32'h1);

    applyStimulus(16'hA5C3, 1'b1, 0);
    applyStimulus(16'hA5C3, 1'b1, 0);
    checkOutput("third bad lockout", 32'(lockoutLvl), 32'h1);
    checkOutput("third bad key", 32'(keyOut), 32'h0);
    applyStimulus(16'h1234, 1'b1, 0);
    checkOutput("locked key", 32'(keyOut), 32'h0);
    checkOutput("locked commit", 32'(commitPulse), 32'h0);

    doReset(1);
    applyPartial(7);
    applyStimulus(16'h0001, 1'b1, 0);
    checkOutput("abort key", 32'(keyOut), 32'h0001);
    checkOutput("abort no err", 32'(mFails), 32'h0);

    applyStimulus(16'hFFFF, 1'b0, 5);
    checkOutput("gappy FFFF key", 32'(keyOut), 32'hFFFF);

    applyStimulus(16'hBEEF, 1'b1, 0);
    checkOutput("BEEF key", 32'(keyOut), 32'hBEEF);
    applyPartial(10);
    doReset(1);
    checkOutput("midload rst key", 32'(keyOut), 32'h0);
    checkOutput("midload rst good", 32'(keyGood), 32'h0);
    checkOutput("midload rst ready", 32'(bitReady), 32'h0);
    applyStimulus(16'h00FF, 1'b0, 0);
    checkOutput("00FF key", 32'(keyOut), 32'h00FF);

    for (int n = 0; n < 40; n++) begin
      if (mLocked && $urandom_range(0, 1) == 0) doReset(1);
      if ($urandom_range(0, 3) == 0) applyPartial($urandom_range(0, KW));
      rk = 16'($urandom);
      rp = (^rk) ^ ($urandom_range(0, 3) == 0);
      applyStimulus(rk, rp, 2);
    end

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
